// File: rtl/nds_pipe_slice_pkg.sv
// Shared definitions for the elastic register pipeline slice: depth limit,
// a ceiling-log2 helper for sizing the occupancy counter, and a
// parameter-legality check expanded inside the modules that need it.
`ifndef NDS_PIPE_PKG_SV
`define NDS_PIPE_PKG_SV

package nds_pipe_pkg;

  localparam int NDS_PIPE_MAX_DEPTH = 8;

  // Ceiling log2 with a floor of 1, so a counter that only ever holds 0
  // still gets a one-bit port.
  function automatic int nds_clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// Stops elaboration when DEPTH is outside 0..NDS_PIPE_MAX_DEPTH or WIDTH < 1.
`define NDS_PIPE_CHECK(D, W) \
  if (((D) < 0) || ((D) > nds_pipe_pkg::NDS_PIPE_MAX_DEPTH) || ((W) < 1)) begin : g_param_error \
    $error("nds_pipe_slice: DEPTH must be 0..8 and WIDTH must be >= 1"); \
  end

`endif

// File: rtl/nds_pipe_slice_stage.sv
// One register stage of the elastic pipeline. REG_READY=0 gives a plain
// valid/data register whose ready looks through to the next stage;
// REG_READY=1 gives a main+skid pair so that ready is a flop output.
module nds_pipe_stage
  import nds_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter bit               REG_READY = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             CK,
  input  logic             R,
  input  logic             FLUSH,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  if (REG_READY == 1'b0) begin : g_plain
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Ready looks through this stage when it is empty or being drained,
    // which lets a bubble collapse the cycle it reaches a stalled stage.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next state: flush clears; otherwise take the upstream word when ready.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (FLUSH) begin
        valid_d = 1'b0;
        data_d  = RST_VAL;
      end else if (in_ready_o) begin
        valid_d = in_valid_i;
        if (in_valid_i) begin
          data_d = in_data_i;
        end
      end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge CK or posedge R) begin
      if (R) begin
        valid_q <= 1'b0;
        data_q  <= RST_VAL;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end else begin : g_skid
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    // Ready is purely the registered "skid is free" flag.
    assign in_ready_o  = !skid_valid_q;
    assign in_fire     = in_valid_i && !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    // Next state: skid drains into main before new input; a word arriving
    // while main is stalled parks in skid.
    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (FLUSH) begin
        main_valid_d = 1'b0;
        main_data_d  = RST_VAL;
        skid_valid_d = 1'b0;
        skid_data_d  = RST_VAL;
      end else if (!main_valid_q || out_ready_i) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = in_fire;
          if (in_fire) begin
            main_data_d = in_data_i;
          end
        end
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end

    // Main and skid registers with asynchronous reset.
    always_ff @(posedge CK or posedge R) begin
      if (R) begin
        main_valid_q <= 1'b0;
        main_data_q  <= RST_VAL;
        skid_valid_q <= 1'b0;
        skid_data_q  <= RST_VAL;
      end else begin
        main_valid_q <= main_valid_d;
        main_data_q  <= main_data_d;
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
  end

endmodule

// File: rtl/nds_pipe_slice.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready on both sides,
// synchronous flush and a registered occupancy count. DEPTH=0 is a wire.
module nds_pipe_slice
  import nds_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter bit               REG_READY = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
  localparam int              OCC_W     = nds_clog2(2 * DEPTH + 1)
) (
  input  logic             CK,
  input  logic             R,
  input  logic             FLUSH,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic [OCC_W-1:0] OCC
);

  `NDS_PIPE_CHECK(DEPTH, WIDTH)

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = CK ^ R ^ FLUSH;
    assign O       = I;
    assign O_VALID = I_VALID;
    assign I_READY = O_READY;
    assign OCC     = '0;
  end else begin : g_pipe
    logic [DEPTH:0]   vld;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] dat [DEPTH+1];
    logic             alive_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer, out_xfer;

    // Holds I_READY low until the first edge after reset is released.
    always_ff @(posedge CK or posedge R) begin
      if (R) begin
        alive_q <= 1'b0;
      end else begin
        alive_q <= 1'b1;
      end
    end

    assign vld[0]     = I_VALID && alive_q;
    assign dat[0]     = I;
    assign rdy[DEPTH] = O_READY;
    assign I_READY    = rdy[0] && alive_q && !FLUSH;
    assign O_VALID    = vld[DEPTH];
    assign O          = dat[DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      nds_pipe_stage #(
        .WIDTH     (WIDTH),
        .REG_READY (REG_READY),
        .RST_VAL   (RST_VAL)
      ) u_stage (
        .CK          (CK),
        .R           (R),
        .FLUSH       (FLUSH),
        .in_valid_i  (vld[gi]),
        .in_ready_o  (rdy[gi]),
        .in_data_i   (dat[gi]),
        .out_valid_o (vld[gi+1]),
        .out_ready_i (rdy[gi+1]),
        .out_data_o  (dat[gi+1])
      );
    end

    assign in_xfer  = I_VALID && I_READY;
    assign out_xfer = O_VALID && O_READY;

    // Occupancy: +1 per accepted word, -1 per delivered word, 0 on flush.
    always_comb begin
      occ_d = occ_q;
      if (FLUSH) begin
        occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (out_xfer && !in_xfer) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end

    // Occupancy register with asynchronous reset.
    always_ff @(posedge CK or posedge R) begin
      if (R) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_d;
      end
    end

    assign OCC = occ_q;
  end

endmodule

// File: tb/tb_nds_pipe_slice.sv
// Bench for nds_pipe_slice: four instances (DEPTH 2/3/2-skid/0) share clock,
// reset and flush; a per-instance queue scoreboard checks order and OCC.
module tb_nds_pipe_slice;

  logic       CK = 1'b0;
  logic       R;
  logic       FLUSH;
  logic       iv   [4];
  logic [7:0] id   [4];
  logic       ordy [4];
  logic       irdy [4];
  logic       ov   [4];
  logic [7:0] od   [4];
  logic [7:0] occ  [4];
  logic [2:0] occ0, occ1, occ2;
  logic [0:0] occ3;

  logic [7:0] sb [4][$];
  int         npop [4];
  logic       acc [4];
  int         checks = 0;
  int         errors = 0;

  always #5 CK = ~CK;

  assign occ[0] = {5'b0, occ0};
  assign occ[1] = {5'b0, occ1};
  assign occ[2] = {5'b0, occ2};
  assign occ[3] = {7'b0, occ3};

  nds_pipe_slice #(.WIDTH(8), .DEPTH(2), .REG_READY(1'b0), .RST_VAL(8'hA5)) u0 (
    .CK(CK), .R(R), .FLUSH(FLUSH), .I_VALID(iv[0]), .I_READY(irdy[0]), .I(id[0]),
    .O_VALID(ov[0]), .O_READY(ordy[0]), .O(od[0]), .OCC(occ0));
  nds_pipe_slice #(.WIDTH(8), .DEPTH(3), .REG_READY(1'b0), .RST_VAL(8'h00)) u1 (
    .CK(CK), .R(R), .FLUSH(FLUSH), .I_VALID(iv[1]), .I_READY(irdy[1]), .I(id[1]),
    .O_VALID(ov[1]), .O_READY(ordy[1]), .O(od[1]), .OCC(occ1));
  nds_pipe_slice #(.WIDTH(8), .DEPTH(2), .REG_READY(1'b1), .RST_VAL(8'hA5)) u2 (
    .CK(CK), .R(R), .FLUSH(FLUSH), .I_VALID(iv[2]), .I_READY(irdy[2]), .I(id[2]),
    .O_VALID(ov[2]), .O_READY(ordy[2]), .O(od[2]), .OCC(occ2));
  nds_pipe_slice #(.WIDTH(8), .DEPTH(0), .REG_READY(1'b0), .RST_VAL(8'h00)) u3 (
    .CK(CK), .R(R), .FLUSH(FLUSH), .I_VALID(iv[3]), .I_READY(irdy[3]), .I(id[3]),
    .O_VALID(ov[3]), .O_READY(ordy[3]), .O(od[3]), .OCC(occ3));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d obs=%0h exp=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) sb[i].delete();
  endtask

  // One clock: sample handshakes before the edge, score, then check OCC.
  task automatic tick();
    logic [7:0] e;
    #1;
    for (int i = 0; i < 4; i++) begin
      acc[i] = iv[i] && irdy[i];
      if (acc[i]) sb[i].push_back(id[i]);
      if (ov[i] && ordy[i]) begin
        checks++;
        assert (sb[i].size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow inst=%0d obs=%0h exp=no_word", i, od[i]);
        end
        if (sb[i].size() != 0) begin
          e = sb[i].pop_front();
          npop[i]++;
          chk("data", i, od[i], e);
        end
      end
    end
    if (FLUSH) clear_sb();
    @(posedge CK);
    @(negedge CK);
    if (R) clear_sb();
    else for (int i = 0; i < 4; i++) chk("occ", i, occ[i], sb[i].size());
  endtask

  initial begin
    int nacc;
    int base;
    R = 1'b1;
    FLUSH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; id[i] = 8'h00; ordy[i] = 1'b1; npop[i] = 0; acc[i] = 1'b0;
    end

    // Reset values
    @(negedge CK);
    @(negedge CK);
    for (int i = 0; i < 3; i += 2) begin
      chk("rst_ovalid", i, ov[i], 1'b0);
      chk("rst_o", i, od[i], 8'hA5);
      chk("rst_occ", i, occ[i], 0);
      chk("rst_irdy", i, irdy[i], 1'b0);
    end
    R = 1'b0;
    tick();
    chk("irdy_after_rst", 0, irdy[0], 1'b1);
    chk("irdy_after_rst", 2, irdy[2], 1'b1);

    // Streaming through DEPTH=3: 1..4 appear from cycle 3, no gaps
    for (int c = 0; c < 9; c++) begin
      iv[1] = (c < 4);
      id[1] = 8'(c + 1);
      #1;
      chk("stream_valid", 1, ov[1], (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("stream_data", 1, od[1], c - 2);
      tick();
    end
    iv[1] = 1'b0;

    // Backpressure, combinational ready
    base = npop[0];
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'd10; tick();
    id[0] = 8'd11; tick();
    id[0] = 8'd12;
    #1;
    chk("bp0_irdy_full", 0, irdy[0], 1'b0);
    chk("bp0_occ_full", 0, occ[0], 2);
    tick();
    ordy[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (acc[0]) iv[0] = 1'b0;
    end
    chk("bp0_delivered", 0, npop[0] - base, 3);

    // Backpressure, registered ready (skid)
    base = npop[2];
    nacc = 0;
    ordy[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      iv[2] = 1'b1;
      id[2] = 8'(20 + nacc);
      tick();
      if (acc[2]) nacc++;
    end
    iv[2] = 1'b0;
    chk("bp1_accepted", 2, nacc, 4);
    chk("bp1_occ", 2, occ[2], 4);
    chk("bp1_irdy_full", 2, irdy[2], 1'b0);
    ordy[2] = 1'b1;
    #1;
    chk("bp1_irdy_registered", 2, irdy[2], 1'b0);
    for (int k = 0; k < 8; k++) tick();
    chk("bp1_delivered", 2, npop[2] - base, 4);

    // Flush beats a simultaneous input
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'd30; tick();
    id[0] = 8'd31; tick();
    chk("fl_occ_before", 0, occ[0], 2);
    id[0] = 8'd32;
    FLUSH = 1'b1;
    #1;
    chk("fl_irdy", 0, irdy[0], 1'b0);
    tick();
    FLUSH = 1'b0;
    iv[0] = 1'b0;
    chk("fl_accepted", 0, acc[0], 1'b0);
    chk("fl_occ", 0, occ[0], 0);
    chk("fl_ovalid", 0, ov[0], 1'b0);
    chk("fl_o", 0, od[0], 8'hA5);
    ordy[0] = 1'b1;
    tick();
    tick();

    // Reset in the middle of a stream
    iv[0] = 1'b1; id[0] = 8'd40; tick();
    id[0] = 8'd41; tick();
    #2;
    R = 1'b1;
    #1;
    clear_sb();
    iv[0] = 1'b0;
    chk("mid_rst_ovalid", 0, ov[0], 1'b0);
    chk("mid_rst_o", 0, od[0], 8'hA5);
    chk("mid_rst_occ", 0, occ[0], 0);
    chk("mid_rst_irdy", 0, irdy[0], 1'b0);
    @(negedge CK);
    R = 1'b0;
    tick();
    chk("mid_rst_irdy_after", 0, irdy[0], 1'b1);
    tick();

    // DEPTH=0 pass-through
    for (int k = 0; k < 6; k++) begin
      iv[3] = 1'($urandom_range(0, 1));
      id[3] = 8'($urandom);
      ordy[3] = 1'($urandom_range(0, 1));
      #1;
      chk("d0_o", 3, od[3], id[3]);
      chk("d0_ovalid", 3, ov[3], iv[3]);
      chk("d0_irdy", 3, irdy[3], ordy[3]);
      tick();
    end

    // Random valid/ready with rare flushes; sources hold until accepted
    for (int i = 0; i < 4; i++) iv[i] = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!iv[i] || acc[i]) begin
          iv[i] = ($urandom_range(0, 3) != 0);
          id[i] = 8'($urandom);
        end
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      FLUSH = ($urandom_range(0, 299) == 0);
      tick();
    end

    // Drain and confirm nothing is left behind
    FLUSH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    for (int k = 0; k < 12; k++) tick();
    for (int i = 0; i < 4; i++) chk("drain_empty", i, sb[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
